jtdd_shared_arb: RTL and testbench
==================================

// Module: jtdd_shared_arb
// PURPOSE
//  Arbitrates the 512-byte shared RAM between the main CPU (com_cs window) and the HD63701 MCU (A15:14=10).
//  Sits between both buses and a single-port jtframe_ram (aw=9, 1-cycle synchronous read latency).
//  Replaces the static "MCU wins" address mux with a registered grant FSM and per-requester wait/valid handshakes.
//  The sub-CPU and MCU wait outputs drive the bus-ban / clock-gate logic.
// PARAMETERS
//  MAX_HOLD  16  cen cycles a requester keeps the grant while the other waits (JTDD_ARB_FAIR_EN only)
//  HW        5   width of hold counter; must satisfy 2**HW > MAX_HOLD
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  cen          in   1  arbitration clock enable; all state updates qualified by cen
//  mcu_haltn    in   1  0 = MCU halted; masks mcu_req
//  cpu_req      in   1  CPU access request (com_cs)
//  cpu_wrn      in   1  CPU write, active-low
//  cpu_addr     in   9  CPU address
//  cpu_dout     in   8  CPU write data
//  cpu_wait     out  1  CPU must stall
//  cpu_rd_valid out  1  ram_q holds CPU read data this cycle
//  mcu_req      in   1  MCU access request (shared_cs)
//  mcu_wrn      in   1  MCU write, active-low
//  mcu_addr     in   9  MCU address
//  mcu_dout     in   8  MCU write data
//  mcu_wait     out  1  MCU must stall
//  mcu_rd_valid out  1  ram_q holds MCU read data this cycle
//  ram_addr     out  9  shared RAM address
//  ram_din      out  8  shared RAM write data
//  ram_we       out  1  shared RAM write strobe
// BEHAVIOUR
//  - States: IDLE, GNT_CPU, GNT_MCU. Register `last` records the last granted side. Reset: IDLE, last=CPU, hold counter=0.
//  - Effective MCU request: mreq = mcu_req & mcu_haltn.
//  - IDLE on cen:
//      * Single request: grant that side.
//      * Both request: grant the side != last (round-robin); the first tie after reset goes to the MCU.
//      * No request: stay in IDLE.
//  - Grant is registered: a request raised in cycle n with cen sees grant from cycle n+1 at the earliest.
//  - GNT_x on cen:
//      * x request low and other side requesting -> GNT_other directly (no IDLE bubble).
//      * x request low and other side idle -> IDLE.
//      * Otherwise stay. `last` <= x on every exit from GNT_x.
//  - Combinational outputs:
//      * ram_addr/ram_din = granted side's bus; in IDLE they follow the CPU bus.
//      * ram_we = (GNT_x) & x_req & ~x_wrn & cen. Exactly one write per cen in grant.
//      * cpu_wait = cpu_req & (state!=GNT_CPU).
//      * mcu_wait = mcu_req & (state!=GNT_MCU); mcu_wait stays asserted while halted.
//  - Read path: x_rd_valid is registered, = 1 the cycle after a cen cycle in GNT_x with x_req & x_wrn; otherwise 0.
//  - mcu_haltn falling while in GNT_MCU: treated as a request drop; releases on the next cen.
//  - Requests toggling between cen pulses are ignored; only cen-cycle values count.
//  - Reset values: ram_we=0, cpu_rd_valid=0, mcu_rd_valid=0. The wait outputs follow their requests
//    (state is IDLE, so any request asserted during reset is waited). Async reset mid-grant aborts with no write issued.
// CONFIGURATION
//  JTDD_ARB_FAIR_EN defined:
//    * Hold counter clears on grant entry and increments each cen in GNT_x while the other side requests.
//    * On reaching MAX_HOLD -> GNT_other, even if x still requests; x then sees wait=1.
//    * Counter saturates and never wraps.
//  JTDD_ARB_FAIR_EN undefined:
//    * No counter logic; a holder keeps the grant until its request drops (MCU can starve the CPU).
// TESTING
//  1. MCU read only, cen=1: mcu_req=1, addr=0x012 -> mcu_wait=1 one cycle, 0 next; mcu_rd_valid=1 one cycle later with ram_q=RAM[0x012].
//  2. Simultaneous first request after reset -> GNT_MCU. Both drop and re-request -> GNT_CPU (round-robin).
//  3. CPU writes 0xA5 to 0x1FF while the MCU requests -> MCU waits, ram_we one pulse, then direct handover with no IDLE cycle.
//  4. FAIR_EN, MAX_HOLD=16: MCU holds a read while the CPU requests -> CPU granted on the 17th cen; without FAIR_EN the CPU waits until mcu_req=0.
//  5. mcu_haltn=0 during GNT_MCU with cpu_req=1 -> GNT_CPU on the next cen; mcu_wait stays 1.
//  6. rst pulse mid-write in GNT_CPU -> IDLE immediately; no ram_we; all *_rd_valid=0.

Source files
------------

// File: rtl/jtdd_shared_arb.sv
// jtdd_shared_arb: registered grant FSM sharing the 512-byte RAM between main CPU and MCU.
// Optional build macro JTDD_ARB_FAIR_EN bounds how long a holder keeps the grant under contention.
module jtdd_shared_arb #(
    parameter int MAX_HOLD = 16,
    parameter int HW       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       mcu_haltn,
    input  logic       cpu_req,
    input  logic       cpu_wrn,
    input  logic [8:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic       cpu_wait,
    output logic       cpu_rd_valid,
    input  logic       mcu_req,
    input  logic       mcu_wrn,
    input  logic [8:0] mcu_addr,
    input  logic [7:0] mcu_dout,
    output logic       mcu_wait,
    output logic       mcu_rd_valid,
    output logic [8:0] ram_addr,
    output logic [7:0] ram_din,
    output logic       ram_we
);
    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_MCU} state_t;

    state_t state, state_nxt;
    logic   last;
    logic   mreq;
    logic   cpu_gnt;
    logic   mcu_gnt;
    logic   expired;

    if (2**HW <= MAX_HOLD) begin : g_hw_check
        $error("HW too narrow to hold MAX_HOLD");
    end

    assign mreq    = mcu_req & mcu_haltn;
    assign cpu_gnt = state == GNT_CPU;
    assign mcu_gnt = state == GNT_MCU;

`ifdef JTDD_ARB_FAIR_EN
    logic [HW-1:0] hold;
    logic          contended;

    assign expired   = hold >= HW'(MAX_HOLD);
    assign contended = (cpu_gnt & mreq) | (mcu_gnt & cpu_req);

    // Hold counter: restarts with every grant change, counts contended cen cycles and stops at MAX_HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold <= '0;
        else if (cen)
            hold <= state_nxt != state ? '0 : hold + HW'(contended & ~expired);
    end
`else
    assign expired = 1'b0;
`endif

    // Next grant: round-robin tie break from IDLE, direct handover when the holder releases or expires
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = cpu_req & mreq ? (last ? GNT_CPU : GNT_MCU) :
                                 cpu_req ? GNT_CPU : mreq ? GNT_MCU : IDLE;
            GNT_CPU: if (~cpu_req | (expired & mreq)) state_nxt = mreq ? GNT_MCU : IDLE;
            GNT_MCU: if (~mreq | (expired & cpu_req)) state_nxt = cpu_req ? GNT_CPU : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant register and last-granted side (0 = CPU, 1 = MCU), both advanced only on cen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b0;
        end else if (cen) begin
            state <= state_nxt;
            if (state != IDLE && state_nxt != state)
                last <= mcu_gnt;
        end
    end

    // Read data is valid the cycle after a granted read is presented on a cen cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rd_valid <= 1'b0;
            mcu_rd_valid <= 1'b0;
        end else begin
            cpu_rd_valid <= cen & cpu_gnt & cpu_req & cpu_wrn;
            mcu_rd_valid <= cen & mcu_gnt & mreq & mcu_wrn;
        end
    end

    // RAM bus follows the granted side (CPU when idle); waits stall any ungranted request
    always_comb begin
        ram_addr = mcu_gnt ? mcu_addr : cpu_addr;
        ram_din  = mcu_gnt ? mcu_dout : cpu_dout;
        ram_we   = cen & ((cpu_gnt & cpu_req & ~cpu_wrn) | (mcu_gnt & mreq & ~mcu_wrn));
        cpu_wait = cpu_req & ~cpu_gnt;
        mcu_wait = mcu_req & ~mcu_gnt;
    end
endmodule

// File: tb/tb_jtdd_shared_arb.sv
// tb_jtdd_shared_arb: directed scenarios plus randomized traffic against a behavioural arbitration model.
module tb_jtdd_shared_arb;
    localparam int MAX_HOLD = 16;
`ifdef JTDD_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       mcu_haltn = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_wrn = 1'b1;
    logic [8:0] cpu_addr = '0;
    logic [7:0] cpu_dout = '0;
    logic       mcu_req = 1'b0;
    logic       mcu_wrn = 1'b1;
    logic [8:0] mcu_addr = '0;
    logic [7:0] mcu_dout = '0;
    logic       cpu_wait, cpu_rd_valid, mcu_wait, mcu_rd_valid, ram_we;
    logic [8:0] ram_addr;
    logic [7:0] ram_din;

    int n_cmp = 0;
    int n_err = 0;

    // RAM behind the arbiter and the reference model state
    logic [7:0] mem[512];
    logic [7:0] ref_mem[512];
    logic [7:0] ram_q = '0;
    bit         seeded = 1'b0;
    int         m_own;
    int         m_last;
    int         m_hold;
    bit         m_cv, m_mv;
    logic [7:0] m_cq, m_mq;

    always #5 clk = ~clk;

    jtdd_shared_arb #(.MAX_HOLD(MAX_HOLD), .HW(5)) dut (
        .clk(clk), .rst(rst), .cen(cen), .mcu_haltn(mcu_haltn),
        .cpu_req(cpu_req), .cpu_wrn(cpu_wrn), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_wait(cpu_wait), .cpu_rd_valid(cpu_rd_valid),
        .mcu_req(mcu_req), .mcu_wrn(mcu_wrn), .mcu_addr(mcu_addr), .mcu_dout(mcu_dout),
        .mcu_wait(mcu_wait), .mcu_rd_valid(mcu_rd_valid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we)
    );

    // side 1 = CPU, side 2 = MCU
    function automatic bit want(int side);
        return side == 1 ? cpu_req : (mcu_req & mcu_haltn);
    endfunction

    // Single-port RAM with 1-cycle read latency, plus the spec-level arbitration model
    always @(posedge clk or posedge rst) begin
        if (!seeded) begin
            for (int i = 0; i < 512; i++) begin
                mem[i] = 8'($urandom);
                ref_mem[i] = mem[i];
            end
            seeded = 1'b1;
        end
        if (rst) begin
            m_own = 0;
            m_last = 1;
            m_hold = 0;
            m_cv = 1'b0;
            m_mv = 1'b0;
        end else begin
            ram_q = mem[ram_addr];
            if (ram_we) mem[ram_addr] = ram_din;
            m_cv = 1'b0;
            m_mv = 1'b0;
            if (cen) begin
                if (m_own == 1 && want(1)) begin
                    if (cpu_wrn) begin m_cv = 1'b1; m_cq = ref_mem[cpu_addr]; end
                    else ref_mem[cpu_addr] = cpu_dout;
                end
                if (m_own == 2 && want(2)) begin
                    if (mcu_wrn) begin m_mv = 1'b1; m_mq = ref_mem[mcu_addr]; end
                    else ref_mem[mcu_addr] = mcu_dout;
                end
                if (m_own == 0) begin
                    if (want(1) && want(2)) m_own = 3 - m_last;
                    else if (want(1)) m_own = 1;
                    else if (want(2)) m_own = 2;
                    m_hold = 0;
                end else if (!want(m_own) || (FAIR && want(3 - m_own) && m_hold == MAX_HOLD)) begin
                    m_last = m_own;
                    m_own = want(3 - m_own) ? 3 - m_own : 0;
                    m_hold = 0;
                end else if (FAIR && want(3 - m_own)) begin
                    m_hold++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic wrn, input logic [8:0] a, input logic [7:0] d);
        cpu_req = req; cpu_wrn = wrn; cpu_addr = a; cpu_dout = d;
    endtask

    task automatic set_mcu(input logic req, input logic wrn, input logic [8:0] a, input logic [7:0] d);
        mcu_req = req; mcu_wrn = wrn; mcu_addr = a; mcu_dout = d;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_cpu(1, 1, 9'h000, 8'h00);
        repeat (3) cyc();
        #2;
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", ram_we); end
        n_cmp++; if (cpu_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_cpu_rdv: got %b want 0", cpu_rd_valid); end
        n_cmp++; if (mcu_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_mcu_rdv: got %b want 0", mcu_rd_valid); end
        n_cmp++; if (cpu_wait !== 1'b1) begin n_err++; $display("FAIL reset_cpu_wait: got %b want 1", cpu_wait); end
        n_cmp++; if (mcu_wait !== 1'b0) begin n_err++; $display("FAIL reset_mcu_wait_idle: got %b want 0", mcu_wait); end
        mcu_req = 1'b1;
        #1;
        n_cmp++; if (mcu_wait !== 1'b1) begin n_err++; $display("FAIL reset_mcu_wait: got %b want 1", mcu_wait); end
        set_cpu(0, 1, 9'h000, 8'h00);
        set_mcu(0, 1, 9'h000, 8'h00);
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_mcu_read();
        logic [7:0] exp_q;
        exp_q = ref_mem[9'h012];
        cyc();
        set_mcu(1, 1, 9'h012, 8'h00);
        #2;
        n_cmp++; if (mcu_wait !== 1'b1) begin n_err++; $display("FAIL mread_wait0: got %b want 1", mcu_wait); end
        cyc();
        #2;
        n_cmp++; if (mcu_wait !== 1'b0) begin n_err++; $display("FAIL mread_wait1: got %b want 0", mcu_wait); end
        n_cmp++; if (mcu_rd_valid !== 1'b0) begin n_err++; $display("FAIL mread_early_valid: got %b want 0", mcu_rd_valid); end
        cyc();
        mcu_req = 1'b0;
        #2;
        n_cmp++; if (mcu_rd_valid !== 1'b1) begin n_err++; $display("FAIL mread_valid: got %b want 1", mcu_rd_valid); end
        n_cmp++; if (ram_q !== exp_q) begin n_err++; $display("FAIL mread_data: got %h want %h", ram_q, exp_q); end
        cyc();
        #2;
        n_cmp++; if (mcu_rd_valid !== 1'b0) begin n_err++; $display("FAIL mread_valid_clear: got %b want 0", mcu_rd_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        cyc();
        set_cpu(1, 1, 9'h020, 8'h00);
        set_mcu(1, 1, 9'h030, 8'h00);
        #2;
        n_cmp++; if ({cpu_wait, mcu_wait} !== 2'b11) begin n_err++; $display("FAIL rr_idle1: got %b want 11", {cpu_wait, mcu_wait}); end
        cyc();
        #2;
        n_cmp++; if ({cpu_wait, mcu_wait} !== 2'b10) begin n_err++; $display("FAIL rr_first_mcu: got %b want 10", {cpu_wait, mcu_wait}); end
        cyc();
        cpu_req = 1'b0; mcu_req = 1'b0;
        cyc();
        cpu_req = 1'b1; mcu_req = 1'b1;
        #2;
        n_cmp++; if ({cpu_wait, mcu_wait} !== 2'b11) begin n_err++; $display("FAIL rr_idle2: got %b want 11", {cpu_wait, mcu_wait}); end
        cyc();
        #2;
        n_cmp++; if ({cpu_wait, mcu_wait} !== 2'b01) begin n_err++; $display("FAIL rr_second_cpu: got %b want 01", {cpu_wait, mcu_wait}); end
        cyc();
        cpu_req = 1'b0; mcu_req = 1'b0;
        cyc();
    endtask

    task automatic test_cpu_write_handover();
        cyc();
        set_cpu(1, 0, 9'h1FF, 8'hA5);
        #2;
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wr_idle_we: got %b want 0", ram_we); end
        cyc();
        set_mcu(1, 1, 9'h1FF, 8'h00);
        #2;
        n_cmp++; if ({cpu_wait, mcu_wait} !== 2'b01) begin n_err++; $display("FAIL wr_waits: got %b want 01", {cpu_wait, mcu_wait}); end
        n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL wr_we: got %b want 1", ram_we); end
        n_cmp++; if (ram_addr !== 9'h1FF) begin n_err++; $display("FAIL wr_addr: got %h want 1ff", ram_addr); end
        n_cmp++; if (ram_din !== 8'hA5) begin n_err++; $display("FAIL wr_din: got %h want a5", ram_din); end
        cyc();
        cpu_req = 1'b0;
        #2;
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wr_single_pulse: got %b want 0", ram_we); end
        n_cmp++; if (mcu_wait !== 1'b1) begin n_err++; $display("FAIL wr_mcu_still_waits: got %b want 1", mcu_wait); end
        cyc();
        #2;
        n_cmp++; if (mcu_wait !== 1'b0) begin n_err++; $display("FAIL wr_direct_handover: got %b want 0", mcu_wait); end
        cyc();
        mcu_req = 1'b0;
        #2;
        n_cmp++; if (mcu_rd_valid !== 1'b1) begin n_err++; $display("FAIL wr_readback_valid: got %b want 1", mcu_rd_valid); end
        n_cmp++; if (ram_q !== 8'hA5) begin n_err++; $display("FAIL wr_readback_data: got %h want a5", ram_q); end
        cyc();
    endtask

    task automatic test_hold();
        cyc();
        set_mcu(1, 1, 9'h040, 8'h00);
        cyc();
        set_cpu(1, 1, 9'h041, 8'h00);
        for (int k = 1; k <= 17; k++) begin
            #2;
            n_cmp++; if (cpu_wait !== 1'b1) begin n_err++; $display("FAIL hold_cpu_wait cen %0d: got %b want 1", k, cpu_wait); end
            cyc();
        end
        #2;
`ifdef JTDD_ARB_FAIR_EN
        n_cmp++; if ({cpu_wait, mcu_wait} !== 2'b01) begin n_err++; $display("FAIL hold_forced_handover: got %b want 01", {cpu_wait, mcu_wait}); end
        cpu_req = 1'b0;
        cyc();
        mcu_req = 1'b0;
`else
        n_cmp++; if ({cpu_wait, mcu_wait} !== 2'b10) begin n_err++; $display("FAIL hold_no_handover: got %b want 10", {cpu_wait, mcu_wait}); end
        repeat (10) cyc();
        mcu_req = 1'b0;
        #2;
        n_cmp++; if (cpu_wait !== 1'b1) begin n_err++; $display("FAIL hold_still_starved: got %b want 1", cpu_wait); end
        cyc();
        #2;
        n_cmp++; if (cpu_wait !== 1'b0) begin n_err++; $display("FAIL hold_release: got %b want 0", cpu_wait); end
        cpu_req = 1'b0;
`endif
        cyc();
        cyc();
    endtask

    task automatic test_halt();
        cyc();
        set_mcu(1, 1, 9'h050, 8'h00);
        cyc();
        set_cpu(1, 1, 9'h051, 8'h00);
        #2;
        n_cmp++; if (cpu_wait !== 1'b1) begin n_err++; $display("FAIL halt_cpu_wait: got %b want 1", cpu_wait); end
        cyc();
        mcu_haltn = 1'b0;
        #2;
        n_cmp++; if (mcu_wait !== 1'b0) begin n_err++; $display("FAIL halt_still_granted: got %b want 0", mcu_wait); end
        cyc();
        #2;
        n_cmp++; if ({cpu_wait, mcu_wait} !== 2'b01) begin n_err++; $display("FAIL halt_release: got %b want 01", {cpu_wait, mcu_wait}); end
        cyc();
        cpu_req = 1'b0;
        #2;
        n_cmp++; if (mcu_wait !== 1'b1) begin n_err++; $display("FAIL halt_mcu_wait_held: got %b want 1", mcu_wait); end
        cyc();
        mcu_req = 1'b0;
        mcu_haltn = 1'b1;
        cyc();
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] exp_q;
        exp_q = ref_mem[9'h055];
        cyc();
        set_cpu(1, 0, 9'h055, ~exp_q);
        cyc();
        #1;
        n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL rstw_we_before: got %b want 1", ram_we); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rstw_we_abort: got %b want 0", ram_we); end
        n_cmp++; if (cpu_wait !== 1'b1) begin n_err++; $display("FAIL rstw_cpu_wait: got %b want 1", cpu_wait); end
        n_cmp++; if ({cpu_rd_valid, mcu_rd_valid} !== 2'b00) begin n_err++; $display("FAIL rstw_rdv: got %b want 00", {cpu_rd_valid, mcu_rd_valid}); end
        cyc();
        cpu_req = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        set_mcu(1, 1, 9'h055, 8'h00);
        cyc();
        cyc();
        mcu_req = 1'b0;
        #2;
        n_cmp++; if (mcu_rd_valid !== 1'b1) begin n_err++; $display("FAIL rstw_readback_valid: got %b want 1", mcu_rd_valid); end
        n_cmp++; if (ram_q !== exp_q) begin n_err++; $display("FAIL rstw_no_write: got %h want %h", ram_q, exp_q); end
        cyc();
    endtask

    task automatic test_random();
        logic       e_cw, e_mw, e_we;
        logic [8:0] e_addr;
        logic [7:0] e_din;
        int         tgl;
        for (int n = 0; n < 4000; n++) begin
            cyc();
            tgl = n < 2000 ? 4 : 30;
            cen = $urandom_range(0, 9) < 7;
            if ($urandom_range(0, tgl - 1) == 0) cpu_req = ~cpu_req;
            if ($urandom_range(0, tgl - 1) == 0) mcu_req = ~mcu_req;
            mcu_haltn = $urandom_range(0, 19) != 0;
            cpu_wrn = 1'($urandom);
            mcu_wrn = 1'($urandom);
            cpu_addr = 9'($urandom);
            mcu_addr = 9'($urandom);
            cpu_dout = 8'($urandom);
            mcu_dout = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                #1;
            end else begin
                #2;
            end
            e_cw = cpu_req && m_own != 1;
            e_mw = mcu_req && m_own != 2;
            e_addr = m_own == 2 ? mcu_addr : cpu_addr;
            e_din = m_own == 2 ? mcu_dout : cpu_dout;
            e_we = cen && ((m_own == 1 && cpu_req && !cpu_wrn) || (m_own == 2 && mcu_req && mcu_haltn && !mcu_wrn));
            n_cmp++; if (cpu_wait !== e_cw) begin n_err++; $display("FAIL rnd_cpu_wait @%0d: got %b want %b", n, cpu_wait, e_cw); end
            n_cmp++; if (mcu_wait !== e_mw) begin n_err++; $display("FAIL rnd_mcu_wait @%0d: got %b want %b", n, mcu_wait, e_mw); end
            n_cmp++; if (ram_we !== e_we) begin n_err++; $display("FAIL rnd_we @%0d: got %b want %b", n, ram_we, e_we); end
            n_cmp++; if (ram_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr @%0d: got %h want %h", n, ram_addr, e_addr); end
            n_cmp++; if (ram_din !== e_din) begin n_err++; $display("FAIL rnd_din @%0d: got %h want %h", n, ram_din, e_din); end
            n_cmp++; if (cpu_rd_valid !== m_cv) begin n_err++; $display("FAIL rnd_cpu_rdv @%0d: got %b want %b", n, cpu_rd_valid, m_cv); end
            n_cmp++; if (mcu_rd_valid !== m_mv) begin n_err++; $display("FAIL rnd_mcu_rdv @%0d: got %b want %b", n, mcu_rd_valid, m_mv); end
            if (m_cv) begin
                n_cmp++; if (ram_q !== m_cq) begin n_err++; $display("FAIL rnd_cpu_data @%0d: got %h want %h", n, ram_q, m_cq); end
            end
            if (m_mv) begin
                n_cmp++; if (ram_q !== m_mq) begin n_err++; $display("FAIL rnd_mcu_data @%0d: got %h want %h", n, ram_q, m_mq); end
            end
        end
        cen = 1'b1;
        mcu_haltn = 1'b1;
        set_cpu(0, 1, 9'h000, 8'h00);
        set_mcu(0, 1, 9'h000, 8'h00);
        cyc();
    endtask

    initial begin
        test_reset();
        test_mcu_read();
        test_round_robin();
        test_cpu_write_handover();
        test_hold();
        test_halt();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
